// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute stage and alu_multicycle.
// The master drives the operation request; the slave returns the handshake and results.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             clear_q;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic [4:0]       ALUFlags;
    logic             QSticky;

    modport master (
        output start, ALUControl, a, b, c, clear_q,
        input  ready, done, Result, ResultHi, ALUFlags, QSticky
    );

    modport slave (
        input  start, ALUControl, a, b, c, clear_q,
        output ready, done, Result, ResultHi, ALUFlags, QSticky
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked execute-stage ALU: single-cycle logic/add/saturating ops plus
// iterative shift-add multiply and restoring divide that take WIDTH extra edges.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             reset,
    alu_multicycle_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_ORR   = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_MLA   = 4'b0101;
    localparam logic [3:0] OP_EOR   = 4'b0110;
    localparam logic [3:0] OP_MVN   = 4'b0111;
    localparam logic [3:0] OP_QADD  = 4'b1000;
    localparam logic [3:0] OP_QSUB  = 4'b1001;
    localparam logic [3:0] OP_UMULL = 4'b1010;
    localparam logic [3:0] OP_SMULL = 4'b1011;
    localparam logic [3:0] OP_UDIV  = 4'b1100;
    localparam logic [3:0] OP_SDIV  = 4'b1101;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   addC_q, addC_d;
    logic [WIDTH-1:0]   aOrig_q, aOrig_d;
    logic               negLo_q, negLo_d;
    logic               negRem_q, negRem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;
    logic [4:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic               qSticky_q, qSticky_d;

    logic [3:0]         opIn;
    logic [WIDTH-1:0]   bEff;
    logic [WIDTH:0]     sum;
    logic               satPos, satNeg;
    logic               isMultiIn, isSignedIn, aNegIn, bNegIn;
    logic [WIDTH-1:0]   scResult;
    logic               scC, scV, scQ;
    logic [4:0]         scFlags;

    assign opIn       = bus.ALUControl;
    assign bEff       = opIn[0] ? ~bus.b : bus.b;
    assign sum        = {1'b0, bus.a} + {1'b0, bEff} + {{WIDTH{1'b0}}, opIn[0]};
    assign satPos     = ~bus.a[WIDTH-1] & ~bEff[WIDTH-1] &  sum[WIDTH-1];
    assign satNeg     =  bus.a[WIDTH-1] &  bEff[WIDTH-1] & ~sum[WIDTH-1];
    assign isMultiIn  = (opIn == OP_MUL)   || (opIn == OP_MLA)   ||
                        (opIn == OP_UMULL) || (opIn == OP_SMULL) ||
                        (opIn == OP_UDIV)  || (opIn == OP_SDIV);
    assign isSignedIn = (opIn == OP_SMULL) || (opIn == OP_SDIV);
    assign aNegIn     = isSignedIn & bus.a[WIDTH-1];
    assign bNegIn     = isSignedIn & bus.b[WIDTH-1];

    // Results for the ops that complete on the accepting edge; reserved opcodes report all-zero flags.
    always_comb begin
        scResult = '0;
        scC      = 1'b0;
        scV      = 1'b0;
        scQ      = 1'b0;
        case (opIn)
            OP_ADD, OP_SUB: begin
                scResult = sum[WIDTH-1:0];
                scC      = sum[WIDTH];
                scV      = (bus.a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  scResult = bus.a & bus.b;
            OP_ORR:  scResult = bus.a | bus.b;
            OP_EOR:  scResult = bus.a ^ bus.b;
            OP_MVN:  scResult = ~bus.b;
            OP_QADD, OP_QSUB: begin
                scQ      = satPos | satNeg;
                scResult = satPos ? MAX_POS : (satNeg ? MIN_NEG : sum[WIDTH-1:0]);
            end
            default: scResult = '0;
        endcase
        scFlags = (opIn[3:1] == 3'b111) ? 5'b00000
                : {scResult[WIDTH-1], (scResult == '0), scC, scV, scQ};
    end

    logic [WIDTH:0]     mulSum;
    logic [WIDTH-1:0]   mulHiNext, mulLoNext;
    logic [WIDTH:0]     divTrial;
    logic               divFits;
    logic [WIDTH-1:0]   divHiNext, divLoNext;
    logic               isDiv;
    logic [2*WIDTH-1:0] longProd;
    logic [WIDTH-1:0]   quot, rem;

    // hi_q/lo_q form a double-width shift register: partial product for multiply,
    // remainder/quotient for divide. Operands are held as magnitudes during RUN.
    assign mulSum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    assign mulHiNext = mulSum[WIDTH:1];
    assign mulLoNext = {mulSum[0], lo_q[WIDTH-1:1]};
    assign divTrial  = {hi_q, lo_q[WIDTH-1]};
    assign divFits   = divTrial >= {1'b0, opB_q};
    assign divHiNext = divFits ? (divTrial[WIDTH-1:0] - opB_q) : divTrial[WIDTH-1:0];
    assign divLoNext = {lo_q[WIDTH-2:0], divFits};
    assign isDiv     = (op_q[3:2] == 2'b11);
    assign longProd  = negLo_q ? -{mulHiNext, mulLoNext} : {mulHiNext, mulLoNext};
    assign quot      = negLo_q ? -divLoNext : divLoNext;
    assign rem       = negRem_q ? -divHiNext : divHiNext;

    // Next-state and output register logic; the final RUN edge finishes from this edge's iteration.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        opB_d      = opB_q;
        addC_d     = addC_q;
        aOrig_d    = aOrig_q;
        negLo_d    = negLo_q;
        negRem_d   = negRem_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d = opIn;
                    if (isMultiIn) begin
                        state_d  = RUN;
                        cnt_d    = CNT_W'(WIDTH);
                        lo_d     = aNegIn ? -bus.a : bus.a;
                        hi_d     = '0;
                        opB_d    = bNegIn ? -bus.b : bus.b;
                        addC_d   = bus.c;
                        aOrig_d  = bus.a;
                        negLo_d  = aNegIn ^ bNegIn;
                        negRem_d = aNegIn;
                    end else begin
                        result_d   = scResult;
                        resultHi_d = '0;
                        flags_d    = scFlags;
                        done_d     = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (isDiv) begin
                    hi_d = divHiNext;
                    lo_d = divLoNext;
                end else begin
                    hi_d = mulHiNext;
                    lo_d = mulLoNext;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_UMULL, OP_SMULL: begin
                            result_d   = longProd[WIDTH-1:0];
                            resultHi_d = longProd[2*WIDTH-1:WIDTH];
                        end
                        OP_UDIV, OP_SDIV: begin
                            if (opB_q == '0) begin
                                result_d   = '0;
                                resultHi_d = aOrig_q;
                            end else begin
                                result_d   = quot;
                                resultHi_d = rem;
                            end
                        end
                        OP_MLA: begin
                            result_d   = mulLoNext + addC_q;
                            resultHi_d = '0;
                        end
                        default: begin
                            result_d   = mulLoNext;
                            resultHi_d = '0;
                        end
                    endcase
                    if (op_q[3:1] == 3'b101) begin
                        flags_d = {longProd[2*WIDTH-1], (longProd == '0), 3'b000};
                    end else begin
                        flags_d = {result_d[WIDTH-1], (result_d == '0), 3'b000};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        qSticky_d = (done_d & flags_d[0]) | (qSticky_q & ~bus.clear_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            opB_q      <= '0;
            addC_q     <= '0;
            aOrig_q    <= '0;
            negLo_q    <= 1'b0;
            negRem_q   <= 1'b0;
            result_q   <= '0;
            resultHi_q <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            qSticky_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            opB_q      <= opB_d;
            addC_q     <= addC_d;
            aOrig_q    <= aOrig_d;
            negLo_q    <= negLo_d;
            negRem_q   <= negRem_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            qSticky_q  <= qSticky_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.ResultHi = resultHi_q;
    assign bus.ALUFlags = flags_q;
    assign bus.QSticky  = qSticky_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle: a 32-bit and an 8-bit instance share one clock.
module tb_alu_multicycle;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_ORR   = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_MLA   = 4'b0101;
    localparam logic [3:0] OP_EOR   = 4'b0110;
    localparam logic [3:0] OP_MVN   = 4'b0111;
    localparam logic [3:0] OP_QADD  = 4'b1000;
    localparam logic [3:0] OP_QSUB  = 4'b1001;
    localparam logic [3:0] OP_UMULL = 4'b1010;
    localparam logic [3:0] OP_SMULL = 4'b1011;
    localparam logic [3:0] OP_UDIV  = 4'b1100;
    localparam logic [3:0] OP_SDIV  = 4'b1101;
    localparam logic [3:0] OP_RSVD  = 4'b1110;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] res;
        logic [31:0] resHi;
        logic [4:0]  flags;
        logic        qs;
        int unsigned doneCycle;
        int unsigned tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset32;
    logic        reset8;
    int unsigned cycle = 0;
    int          tests = 0;
    int          failures = 0;
    int unsigned tagNext = 0;
    int          lowCycles;
    int          drainWait;
    exp_t        sb32[$];
    exp_t        sb8[$];
    exp_t        m32;
    exp_t        m8;

    alu_multicycle_if #(.WIDTH(32)) bus32 ();
    alu_multicycle_if #(.WIDTH(8))  bus8 ();

    alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32));
    alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Issue one operation on the chosen instance and push its expected response.
    task automatic applyStimulus(input bit unit8, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input logic [31:0] expRes, input logic [31:0] expHi,
                                 input logic [4:0] expFlags, input logic expQs);
        exp_t e;
        int   waitCnt;
        bit   multi;
        logic rdy;
        waitCnt = 0;
        multi = (op == OP_MUL) || (op == OP_MLA) || (op == OP_UMULL) ||
                (op == OP_SMULL) || (op == OP_UDIV) || (op == OP_SDIV);
        @(negedge clk);
        rdy = unit8 ? bus8.ready : bus32.ready;
        while (!rdy && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
            rdy = unit8 ? bus8.ready : bus32.ready;
        end
        checkOutput($sformatf("tag%0d_ready_before_issue", tagNext), {63'b0, rdy}, 64'd1);
        e.op        = op;
        e.res       = expRes;
        e.resHi     = expHi;
        e.flags     = expFlags;
        e.qs        = expQs;
        e.tag       = tagNext;
        e.doneCycle = cycle + 32'd1 + (multi ? (unit8 ? 32'd8 : 32'd32) : 32'd0);
        tagNext++;
        if (unit8) begin
            bus8.ALUControl = op;
            bus8.a          = a[7:0];
            bus8.b          = b[7:0];
            bus8.c          = c[7:0];
            bus8.start      = 1'b1;
            sb8.push_back(e);
        end else begin
            bus32.ALUControl = op;
            bus32.a          = a;
            bus32.b          = b;
            bus32.c          = c;
            bus32.start      = 1'b1;
            sb32.push_back(e);
        end
        @(posedge clk);
        #1;
        if (unit8) bus8.start = 1'b0;
        else       bus32.start = 1'b0;
    endtask

    // Monitor for the 32-bit instance: every done must match the oldest expected entry.
    always @(posedge clk) begin
        #1;
        if (bus32.done === 1'b1) begin
            if (sb32.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL dut32_unexpected_done: got done=1, want done=0 (nothing outstanding)");
            end else begin
                m32 = sb32.pop_front();
                checkOutput($sformatf("dut32_tag%0d_Result", m32.tag),   {32'b0, bus32.Result},   {32'b0, m32.res});
                checkOutput($sformatf("dut32_tag%0d_ResultHi", m32.tag), {32'b0, bus32.ResultHi}, {32'b0, m32.resHi});
                checkOutput($sformatf("dut32_tag%0d_ALUFlags", m32.tag), {59'b0, bus32.ALUFlags}, {59'b0, m32.flags});
                checkOutput($sformatf("dut32_tag%0d_QSticky", m32.tag),  {63'b0, bus32.QSticky},  {63'b0, m32.qs});
                checkOutput($sformatf("dut32_tag%0d_done_cycle", m32.tag), {32'b0, cycle}, {32'b0, m32.doneCycle});
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(posedge clk) begin
        #1;
        if (bus8.done === 1'b1) begin
            if (sb8.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL dut8_unexpected_done: got done=1, want done=0 (nothing outstanding)");
            end else begin
                m8 = sb8.pop_front();
                checkOutput($sformatf("dut8_tag%0d_Result", m8.tag),   {56'b0, bus8.Result},   {32'b0, m8.res});
                checkOutput($sformatf("dut8_tag%0d_ResultHi", m8.tag), {56'b0, bus8.ResultHi}, {32'b0, m8.resHi});
                checkOutput($sformatf("dut8_tag%0d_ALUFlags", m8.tag), {59'b0, bus8.ALUFlags}, {59'b0, m8.flags});
                checkOutput($sformatf("dut8_tag%0d_QSticky", m8.tag),  {63'b0, bus8.QSticky},  {63'b0, m8.qs});
                checkOutput($sformatf("dut8_tag%0d_done_cycle", m8.tag), {32'b0, cycle}, {32'b0, m8.doneCycle});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset32          = 1'b1;
        reset8           = 1'b1;
        bus32.start      = 1'b0;
        bus32.ALUControl = 4'b0;
        bus32.a          = '0;
        bus32.b          = '0;
        bus32.c          = '0;
        bus32.clear_q    = 1'b0;
        bus8.start       = 1'b0;
        bus8.ALUControl  = 4'b0;
        bus8.a           = '0;
        bus8.b           = '0;
        bus8.c           = '0;
        bus8.clear_q     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready",    {63'b0, bus32.ready},    64'd1);
        checkOutput("reset_done",     {63'b0, bus32.done},     64'd0);
        checkOutput("reset_Result",   {32'b0, bus32.Result},   64'd0);
        checkOutput("reset_ResultHi", {32'b0, bus32.ResultHi}, 64'd0);
        checkOutput("reset_ALUFlags", {59'b0, bus32.ALUFlags}, 64'd0);
        checkOutput("reset_QSticky",  {63'b0, bus32.QSticky},  64'd0);
        reset32 = 1'b0;
        reset8  = 1'b0;

        // 32-bit single-cycle ops, issued back to back
        applyStimulus(0, OP_ADD,  32'hFFFF_FFFF, 32'h1,  32'h0, 32'h0000_0000, 32'h0, 5'b01100, 1'b0);
        applyStimulus(0, OP_QADD, 32'h7FFF_FFF0, 32'h20, 32'h0, 32'h7FFF_FFFF, 32'h0, 5'b00001, 1'b1);
        applyStimulus(0, OP_QSUB, 32'h8000_0000, 32'h1,  32'h0, 32'h8000_0000, 32'h0, 5'b10001, 1'b1);
        applyStimulus(0, OP_QSUB, 32'h5,         32'h7,  32'h0, 32'hFFFF_FFFE, 32'h0, 5'b10000, 1'b1);
        @(negedge clk);
        bus32.clear_q = 1'b1;
        @(posedge clk);
        #1;
        bus32.clear_q = 1'b0;
        checkOutput("qsticky_after_clear", {63'b0, bus32.QSticky}, 64'd0);
        applyStimulus(0, OP_SUB,  32'h8000_0000, 32'h1,  32'h0, 32'h7FFF_FFFF, 32'h0, 5'b00110, 1'b0);

        // Long multiply with ready-low window measurement
        applyStimulus(0, OP_SMULL, 32'hFFFF_FFFD, 32'h7, 32'h0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 5'b10000, 1'b0);
        lowCycles = 0;
        @(negedge clk);
        while (!bus32.ready && lowCycles < 100) begin
            lowCycles++;
            @(negedge clk);
        end
        checkOutput("smull_ready_low_cycles", 64'(lowCycles), 64'd32);

        applyStimulus(0, OP_SDIV,  32'hFFFF_FFF9, 32'h2,         32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b10000, 1'b0);
        applyStimulus(0, OP_UDIV,  32'h9,         32'h0,         32'h0, 32'h0,         32'h9,         5'b01000, 1'b0);
        applyStimulus(0, OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 5'b10000, 1'b0);

        // start held during a MUL run must be ignored
        applyStimulus(0, OP_MUL, 32'h6, 32'h7, 32'h0, 32'h2A, 32'h0, 5'b00000, 1'b0);
        repeat (2) @(negedge clk);
        bus32.ALUControl = OP_ADD;
        bus32.a          = 32'h1;
        bus32.b          = 32'h1;
        bus32.start      = 1'b1;
        repeat (10) @(negedge clk);
        bus32.start      = 1'b0;

        applyStimulus(0, OP_RSVD, 32'h1,         32'h2,         32'h0, 32'h0,         32'h0, 5'b00000, 1'b0);
        applyStimulus(0, OP_QADD, 32'h7FFF_FFFF, 32'h1,         32'h0, 32'h7FFF_FFFF, 32'h0, 5'b00001, 1'b1);
        applyStimulus(0, OP_MVN,  32'h0,         32'h0,         32'h0, 32'hFFFF_FFFF, 32'h0, 5'b10000, 1'b1);

        // Reset in the middle of a divide discards it
        applyStimulus(0, OP_UDIV, 32'd100, 32'd7, 32'h0, 32'd14, 32'd2, 5'b00000, 1'b1);
        repeat (5) @(negedge clk);
        reset32 = 1'b1;
        sb32.delete();
        #1;
        checkOutput("midrun_reset_ready",    {63'b0, bus32.ready},    64'd1);
        checkOutput("midrun_reset_done",     {63'b0, bus32.done},     64'd0);
        checkOutput("midrun_reset_Result",   {32'b0, bus32.Result},   64'd0);
        checkOutput("midrun_reset_ALUFlags", {59'b0, bus32.ALUFlags}, 64'd0);
        checkOutput("midrun_reset_QSticky",  {63'b0, bus32.QSticky},  64'd0);
        @(negedge clk);
        reset32 = 1'b0;
        repeat (45) @(negedge clk);
        checkOutput("after_reset_Result_held", {32'b0, bus32.Result}, 64'd0);
        applyStimulus(0, OP_ADD, 32'h2, 32'h3, 32'h0, 32'h5, 32'h0, 5'b00000, 1'b0);

        // 8-bit instance
        applyStimulus(1, OP_MLA,  32'd16,  32'd16,  32'd3, 32'h03, 32'h00, 5'b00000, 1'b0);
        applyStimulus(1, OP_EOR,  32'hF0,  32'h3C,  32'h0, 32'hCC, 32'h00, 5'b10000, 1'b0);
        applyStimulus(1, OP_AND,  32'hF0,  32'h0F,  32'h0, 32'h00, 32'h00, 5'b01000, 1'b0);
        applyStimulus(1, OP_ORR,  32'h50,  32'h05,  32'h0, 32'h55, 32'h00, 5'b00000, 1'b0);
        applyStimulus(1, OP_SDIV, 32'h80,  32'hFF,  32'h0, 32'h80, 32'h00, 5'b10000, 1'b0);
        applyStimulus(1, OP_UDIV, 32'd200, 32'd7,   32'h0, 32'h1C, 32'h04, 5'b00000, 1'b0);

        drainWait = 0;
        while ((sb32.size() != 0 || sb8.size() != 0) && drainWait < 200) begin
            @(negedge clk);
            drainWait++;
        end
        checkOutput("sb32_drained", 64'(sb32.size()), 64'd0);
        checkOutput("sb8_drained",  64'(sb8.size()),  64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Supports WIDTH-bit operands and adds long multiply (UMULL/SMULL) and divide (UDIV/SDIV) through an iterative shift-add/restoring engine.
- Fixes QSUB saturation detection (operand b is inverted before the check) and keeps a sticky Q flag.
- Sits in the execute stage; the pipeline stalls while ready=0.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  operation request; accepted only when ready=1
- ALUControl  in  4  opcode, latched on accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c  in  WIDTH  MLA accumulate operand
- clear_q  in  1  clears QSticky
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse; Result/ResultHi/ALUFlags valid
- Result  out  WIDTH  low result / quotient
- ResultHi  out  WIDTH  high product / remainder; 0 for other ops
- ALUFlags  out  5  {N,Z,C,V,Q}
- QSticky  out  1  accumulated saturation flag

Behaviour:
- Reset (async, any state): state=IDLE; Result, ResultHi, ALUFlags=0; done=0; QSticky=0. An in-flight operation is discarded and produces no done.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 MUL, 0101 MLA (a*b+c, low WIDTH), 0110 EOR, 0111 MVN (~b).
  - 1000 QADD, 1001 QSUB.
  - 1010 UMULL, 1011 SMULL.
  - 1100 UDIV, 1101 SDIV.
  - 111x reserved: Result=0, flags=0, single-cycle.
- States: IDLE, RUN.
- Accept: at a rising edge with start=1 and state=IDLE, operands and opcode are latched. start is ignored in RUN.
- Single-cycle ops (000x-0111 except MUL/MLA, 100x, 111x): result registered at the accepting edge; done=1 for the following cycle; state stays IDLE. Latency 1, throughput 1/cycle (back-to-back start allowed).
- MUL/MLA/UMULL/SMULL/UDIV/SDIV:
  - Accepting edge: go RUN with counter=WIDTH; signed ops store operand magnitudes and the result sign.
  - Each RUN edge performs one iteration and decrements the counter.
  - Counter reaching 0: apply sign correction (and +c for MLA), register outputs, return to IDLE, done=1 for the next cycle.
  - Latency WIDTH+1 edges from accept to done; ready=0 for WIDTH cycles.
- Arithmetic:
  - ADD/SUB use a + (b or ~b) + op[0] with WIDTH+1-bit carry.
  - QADD/QSUB use the same sum with effective b' = op[0] ? ~b : b:
    - sat_pos = ~a[W-1] & ~b'[W-1] & sum[W-1] -> Result = 0x7F..F.
    - sat_neg = a[W-1] & b'[W-1] & ~sum[W-1] -> Result = 0x80..0.
    - Otherwise Result = sum.
  - UMULL/SMULL: {ResultHi,Result} = full 2*WIDTH product.
  - UDIV/SDIV: quotient in Result, remainder in ResultHi. Signed quotient truncates toward zero; remainder takes the sign of a.
- Boundary cases:
  - Divide by zero: Result=0, ResultHi=a, full latency.
  - SDIV min/-1: Result=0x80..0, ResultHi=0.
- Flags:
  - N = MSB of Result (UMULL/SMULL: MSB of ResultHi).
  - Z = Result==0 (long multiply: both halves zero).
  - C = carry out, V = signed overflow: ADD/SUB only, 0 otherwise.
  - Q = sat_pos|sat_neg for QADD/QSUB, 0 otherwise.
- QSticky: set on an edge where done is being asserted with Q=1; cleared by clear_q. Simultaneous set and clear: set wins.
- Outputs hold their last value between done pulses.

Test Plan:
- Reset, then ADD a=0xFFFFFFFF b=1 -> done next cycle; Result=0; ALUFlags=N0 Z1 C1 V0 Q0.
- QADD a=0x7FFFFFF0 b=0x20 -> Result=0x7FFFFFFF, Q=1, QSticky=1. Then QSUB a=0x80000000 b=1 -> Result=0x80000000, Q=1. Then QSUB a=5 b=7 -> Result=0xFFFFFFFE, Q=0, QSticky still 1 until clear_q.
- SMULL a=-3 b=7 -> ready low 32 cycles; done at edge 33; {ResultHi,Result}=0xFFFFFFFF_FFFFFFEB; N=1.
- SDIV a=-7 b=2 -> Result=0xFFFFFFFD, ResultHi=0xFFFFFFFF. UDIV by 0 with a=9 -> Result=0, ResultHi=9.
- start asserted during RUN of MUL -> ignored, single done. Reset asserted mid-UDIV -> ready=1 immediately, no done, outputs 0.
- WIDTH=8 instance: MLA a=16 b=16 c=3 -> Result=0x03; back-to-back EOR/AND starts -> a done every cycle.
